// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between the host loader,
// the core data port and the core instruction-fetch port. One access per
// cycle, combinational grant, one-cycle read return steered to its owner.
// A load mode gives the host exclusive ownership and stalls the core.
module sram_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_mode,
  output logic          core_stall,
  input  logic          h_req,
  input  logic          d_req,
  input  logic          i_req,
  input  logic          h_we,
  input  logic          d_we,
  input  logic [3:0]    h_wmask,
  input  logic [3:0]    d_wmask,
  input  logic [AW-1:0] h_addr,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic [DW-1:0] d_wdata,
  output logic          h_gnt,
  output logic          d_gnt,
  output logic          i_gnt,
  output logic          h_rvalid,
  output logic          d_rvalid,
  output logic          i_rvalid,
  output logic [DW-1:0] rdata,
  output logic          sram_csb,
  output logic          sram_web,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  typedef enum logic {RUN, LOAD} mode_e;
  typedef enum logic [1:0] {OWN_H = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2} owner_e;

  mode_e  mode_q, mode_d;
  logic   last_data_q, last_data_d;   // 1: data port was granted last, 0: ifetch
  logic   rd_valid_q, rd_valid_d;
  owner_e rd_owner_q, rd_owner_d;
  logic   core_en;
  logic   rd_take;

  // Grant: host has fixed priority; data and ifetch share round-robin and are
  // locked out both in LOAD and as soon as load_mode is requested. Reset
  // gates every grant so nothing reaches the SRAM while rst_n is low.
  always_comb begin
    core_en = rst_n && (mode_q == RUN) && !load_mode;
    h_gnt   = rst_n && h_req;
    d_gnt   = core_en && !h_req && d_req && (!i_req || !last_data_q);
    i_gnt   = core_en && !h_req && i_req && (!d_req || last_data_q);
  end

  // Stall the core in LOAD and on the RUN cycle where load_mode is raised.
  always_comb begin
    core_stall = rst_n && ((mode_q == LOAD) || load_mode);
  end

  // SRAM command mux: idle drives an inactive command with zeroed fields.
  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (h_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~h_we;
      sram_wmask = h_wmask;
      sram_addr  = h_addr;
      sram_wdata = h_wdata;
    end else if (d_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~d_we;
      sram_wmask = d_wmask;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_csb   = 1'b0;
      sram_addr  = i_addr;
    end
  end

  // Next state: read-return tag, round-robin pointer and mode transitions.
  // Mode changes wait until no read is in flight so its data is not lost.
  always_comb begin
    rd_take     = (h_gnt && !h_we) || (d_gnt && !d_we) || i_gnt;
    rd_valid_d  = rd_take;
    rd_owner_d  = h_gnt ? OWN_H : (d_gnt ? OWN_D : OWN_I);
    last_data_d = last_data_q;
    if (d_gnt) begin
      last_data_d = 1'b1;
    end else if (i_gnt) begin
      last_data_d = 1'b0;
    end
    mode_d = mode_q;
    case (mode_q)
      RUN:     if (load_mode && !rd_valid_q)  mode_d = LOAD;
      LOAD:    if (!load_mode && !rd_valid_q) mode_d = RUN;
      default: mode_d = RUN;
    endcase
  end

  // State registers; async reset drops any pending read return.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= RUN;
      last_data_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= OWN_H;
    end else begin
      mode_q      <= mode_d;
      last_data_q <= last_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // Read return: one-cycle pulse to the owner, data straight from the SRAM.
  always_comb begin
    h_rvalid = rd_valid_q && (rd_owner_q == OWN_H);
    d_rvalid = rd_valid_q && (rd_owner_q == OWN_D);
    i_rvalid = rd_valid_q && (rd_owner_q == OWN_I);
    rdata    = sram_rdata;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the single-port 512x32 `custom_sram` between three requesters: the Wishbone host loader, the core0 data port and the core0 instruction-fetch port. Issues at most one SRAM access per cycle and routes the one-cycle-latency read data back to the owner of the read. Provides a load mode in which the host owns the SRAM exclusively and the core is held in stall. Sits in the user project wrapper between `core0` and `custom_sram`.

## Interface
Parameters:
- `AW`, 9, SRAM word-address width (512 words)
- `DW`, 32, data width

Ports:
- `clk`  in  1  single clock for the block and SRAM
- `rst_n`  in  1  asynchronous, active-low reset
- `load_mode`  in  1  host-exclusive mode request (from LA/config register)
- `core_stall`  out  1  high while the core must not proceed (load mode active)
- `h_req, d_req, i_req`  in  1 each  access request (host, data, ifetch)
- `h_we, d_we`  in  1 each  write enable (ifetch is read-only)
- `h_wmask, d_wmask`  in  4 each  byte write mask
- `h_addr, d_addr, i_addr`  in  AW each  word address
- `h_wdata, d_wdata`  in  DW each  write data
- `h_gnt, d_gnt, i_gnt`  out  1 each  access accepted this cycle
- `h_rvalid, d_rvalid, i_rvalid`  out  1 each  read data valid (one cycle after grant)
- `rdata`  out  DW  shared read data, qualified by the `*_rvalid` lines
- `sram_csb`  out  1  SRAM chip select, active low
- `sram_web`  out  1  SRAM write enable, active low
- `sram_wmask`  out  4  byte mask to SRAM
- `sram_addr`  out  AW  SRAM address
- `sram_wdata`  out  DW  SRAM write data
- `sram_rdata`  in  DW  SRAM read data, valid one cycle after a read command

## Operation
- Mode FSM, states RUN and LOAD. Reset → RUN.
  - RUN → LOAD when `load_mode`=1 and no read is outstanding (rvalid pipe empty); otherwise stay in RUN one more cycle (transition deferred, not dropped).
  - LOAD → RUN when `load_mode`=0 and no read outstanding.
  - `core_stall`=1 in LOAD and on the RUN cycle in which `load_mode`=1 (registered state OR input).
- Arbitration (combinational grant, one grant max per cycle):
  - LOAD: only host eligible; `d_gnt`=`i_gnt`=0 regardless of requests.
  - RUN: host highest fixed priority. Data vs ifetch round-robin: `last` pointer (reset = ifetch, so data wins the first tie); winner of a tie is the one not granted last; `last` updates only on a data or ifetch grant.
  - Requester holds `req`, `addr`, `we`, `wdata`, `wmask` stable until its `gnt`.
- SRAM drive: on a grant, `sram_csb`=0, `sram_web`=~we, address/data/mask from the winner; ifetch always reads. No grant → `sram_csb`=1, other SRAM outputs 0.
- Read return: on a granted read, register owner ID (2 bits) and valid; next cycle assert that owner's `*_rvalid` for exactly one cycle, `rdata`=`sram_rdata`. Writes produce no rvalid. `rdata` = `sram_rdata` unregistered pass-through.
- Back-to-back reads from any mix of requesters are fully pipelined (one per cycle).
- Address is word-indexed and AW wide; no range checking, no wrap logic needed.

## Timing
- Reset (async assert, sync deassert via `rst_n`): state RUN, `last`=ifetch, rvalid pipe empty; all `*_gnt`, `*_rvalid`, `core_stall`=0, `sram_csb`=1, `sram_web`=1, other SRAM outputs 0.
- Grant latency 0 cycles (same cycle as req when eligible); read latency 1 cycle after grant.
- Reset asserted mid-read: pending rvalid is discarded; no rvalid after reset release.
- Simultaneous h/d/i requests in RUN: host granted, `last` unchanged.
- `load_mode` rising while a read is in flight: grants to d/i stop immediately (stall asserted), rvalid still delivered, LOAD entered next cycle.

## Test plan
- Reset: hold `rst_n`=0 with all reqs high → all gnt/rvalid 0, `sram_csb`=1; release → first cycle grants host.
- Host write 0xDEADBEEF to addr 5 then read addr 5 → `h_gnt` each cycle, `h_rvalid`=1 with `rdata`=0xDEADBEEF in cycle after read grant.
- d_req and i_req held continuously, h_req=0 → grants alternate d,i,d,i for 8 cycles; rvalids alternate one cycle later.
- All three requesting for 3 cycles, then host drops → 3 host grants, then data granted (last=ifetch from reset).
- `load_mode`=1 with ifetch read in flight → `core_stall`=1 same cycle, `i_rvalid` delivered next cycle, LOAD entered, d/i requests never granted until `load_mode`=0 and RUN re-entered.
- Async reset asserted the cycle after a data read grant → no `d_rvalid` ever appears.
